// File: rtl/crc_pkg.sv
// Shared CRC-16 (x^16+x^12+x^5+1) constants and state type for the checker and generator.
package crc_pkg;
    localparam int          CRC_W      = 16;
    localparam logic [15:0] CRC_POLY   = 16'h1021;
    localparam int          CODEWORD_W = 48;
    localparam int          CNT_W      = 6;
    localparam logic [5:0]  LAST_BIT   = 6'd47;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } crc_state_e;
endpackage

// File: rtl/crc_check_if.sv
// Codeword-in / result-out handshake bundle for the CRC checker.
interface crc_check_if
    import crc_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_W-1:0]    data;
    logic [CRC_W-1:0]     crc_in;
    logic                 out_valid;
    logic                 out_ready;
    logic                 crc_ok;
    logic [CRC_W-1:0]     syndrome;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output in_valid, data, crc_in, out_ready,
        input  in_ready, out_valid, crc_ok, syndrome, err_count
    );

    modport slave (
        input  in_valid, data, crc_in, out_ready,
        output in_ready, out_valid, crc_ok, syndrome, err_count
    );
endinterface

// File: rtl/crc16_lfsr_step.sv
// One-bit update of a CRC-16 LFSR, MSB-first, no reflection.
module crc16_lfsr_step
    import crc_pkg::*;
(
    input  logic [CRC_W-1:0] lfsr,
    input  logic             data_bit,
    output logic [CRC_W-1:0] next
);
    logic fb;

    assign fb   = lfsr[CRC_W-1] ^ data_bit;
    assign next = {lfsr[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
endmodule

// File: rtl/crc_check.sv
// Serial CRC-16 checker: captures a 48-bit codeword, shifts it MSB-first through
// the LFSR and reports the remainder, counting failed checks with saturation.
module crc_check
    import crc_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ERR_CNT_W = 8
)(
    input  logic       clk,
    input  logic       reset,
    crc_check_if.slave bus
);
    crc_state_e             state;
    crc_state_e             next_state;
    logic [CODEWORD_W-1:0]  shreg;
    logic [CRC_W-1:0]       lfsr;
    logic [CRC_W-1:0]       lfsr_next;
    logic [CNT_W-1:0]       cnt;
    logic [ERR_CNT_W-1:0]   err_cnt;
    logic                   accept;
    logic                   retire;

    assign accept = (state == IDLE) && bus.in_valid;
    assign retire = (state == DONE) && bus.out_ready;

    crc16_lfsr_step u_step (
        .lfsr     (lfsr),
        .data_bit (shreg[CODEWORD_W-1]),
        .next     (lfsr_next)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: next_state is defaulted first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.in_valid)  next_state = SHIFT;
            SHIFT:   if (cnt == '0)     next_state = DONE;
            DONE:    if (bus.out_ready) next_state = IDLE;
            default:                    next_state = IDLE;
        endcase
    end

    // The codeword is shifted left so the bit being checked is always at the top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
            lfsr  <= '0;
            cnt   <= LAST_BIT;
        end else if (accept) begin
            shreg <= {bus.data, bus.crc_in};
            lfsr  <= '0;
            cnt   <= LAST_BIT;
        end else if (state == SHIFT) begin
            shreg <= {shreg[CODEWORD_W-2:0], 1'b0};
            lfsr  <= lfsr_next;
            cnt   <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (retire && (lfsr != '0) && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.crc_ok    = (state == DONE) && (lfsr == '0);
        bus.syndrome  = (state == DONE) ? lfsr : '0;
        bus.err_count = err_cnt;
    end
endmodule

// File: tb/tb_crc_check.sv
// Self-checking bench for crc_check: transaction-level polynomial model compared every
// cycle, plus directed vectors with hand-computed CRC values.
module tb_crc_check;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    crc_check_if ifc ();

    crc_check dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Polynomial long division by G = x^16+x^12+x^5+1.
    function automatic logic [15:0] mod_g(input logic [63:0] v_in);
        logic [63:0] v;
        v = v_in;
        for (int i = 63; i >= 16; i--)
            if (v[i]) v = v ^ (64'h11021 << (i - 16));
        return v[15:0];
    endfunction

    // The LFSR leaves codeword(x)*x^16 mod G, so a bit-0 error reads back as 0x1021.
    function automatic logic [15:0] crc_rem(input logic [47:0] cw);
        return mod_g({cw, 16'h0000});
    endfunction

    function automatic logic [15:0] crc_gen(input logic [31:0] d);
        return mod_g({16'h0000, d, 16'h0000});
    endfunction

    // Transaction model: idle, busy for 48 edges after acceptance, then holding a result.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [15:0] m_res  = 16'h0;
    int          m_err  = 0;
    int          m_t    = 0;
    int          cyc    = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_err  = 0;
        end else begin
            if (!m_busy && !m_done) begin
                if (ifc.in_valid) begin
                    m_busy = 1'b1;
                    m_t    = cyc;
                    m_res  = crc_rem({ifc.data, ifc.crc_in});
                end
            end else if (m_busy) begin
                if (cyc - m_t == 48) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (ifc.out_ready) begin
                m_done = 1'b0;
                if (m_res != 16'h0 && m_err < 255) m_err++;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        check("cmp_in_ready",  32'(ifc.in_ready),  32'(!m_busy && !m_done));
        check("cmp_out_valid", 32'(ifc.out_valid), 32'(m_done));
        check("cmp_crc_ok",    32'(ifc.crc_ok),    32'(m_done && m_res == 16'h0));
        check("cmp_syndrome",  32'(ifc.syndrome),  32'(m_done ? m_res : 16'h0));
        check("cmp_err_count", 32'(ifc.err_count), 32'(m_err));
    end

    task automatic wait_ready();
        int n = 0;
        while (!ifc.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.in_ready) timeout("wait_in_ready");
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!ifc.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.out_valid) timeout("wait_out_valid");
    endtask

    // Called at a negedge; leaves the bench at a negedge with the result retired.
    task automatic run(input logic [31:0] d, input logic [15:0] c, input logic [15:0] exp_syn);
        int n;
        wait_ready();
        ifc.data     = d;
        ifc.crc_in   = c;
        ifc.in_valid = 1'b1;
        @(negedge clk);
        ifc.in_valid = 1'b0;
        check("accepted", 32'(ifc.in_ready), 32'd0);
        wait_valid(n);
        check("latency",  32'(n), 32'd48);
        check("crc_ok",   32'(ifc.crc_ok), 32'(exp_syn == 16'h0));
        check("syndrome", 32'(ifc.syndrome), 32'(exp_syn));
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        check("retired", 32'(ifc.in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] exp_syn;
        int n;
        ifc.in_valid  = 1'b0;
        ifc.data      = '0;
        ifc.crc_in    = '0;
        ifc.out_ready = 1'b0;

        @(negedge clk);
        check("rst_in_ready",  32'(ifc.in_ready),  32'd1);
        check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_crc_ok",    32'(ifc.crc_ok),    32'd0);
        check("rst_syndrome",  32'(ifc.syndrome),  32'd0);
        check("rst_err_count", 32'(ifc.err_count), 32'd0);

        check("pin_gen_1",     32'(crc_gen(32'h0000_0001)), 32'h1021);
        check("pin_gen_x32",   32'(crc_gen(32'h0001_0000)), 32'h3730);
        check("pin_rem_err",   32'(crc_rem({32'h1, 16'h1020})), 32'h1021);

        // Release reset and present a codeword on the same negedge: first edge accepts.
        @(negedge clk);
        reset = 1'b0;
        run(32'h0000_0000, 16'h0000, 16'h0000);
        check("err_zero", 32'(ifc.err_count), 32'd0);
        run(32'h0000_0001, 16'h1021, 16'h0000);
        run(32'h0001_0000, 16'h3730, 16'h0000);
        run(32'h0000_0001, 16'h1020, 16'h1021);
        check("err_single", 32'(ifc.err_count), 32'd1);
        run(32'hDEAD_BEEF, crc_gen(32'hDEAD_BEEF), 16'h0000);
        run(32'h1234_5678, 16'hFFFF, crc_rem({32'h1234_5678, 16'hFFFF}));
        check("err_two", 32'(ifc.err_count), 32'd2);

        // Result held under back-pressure; new in_valid is ignored while DONE.
        exp_syn = crc_rem({32'hCAFE_F00D, 16'h1234});
        wait_ready();
        ifc.data     = 32'hCAFE_F00D;
        ifc.crc_in   = 16'h1234;
        ifc.in_valid = 1'b1;
        @(negedge clk);
        ifc.in_valid = 1'b0;
        wait_valid(n);
        ifc.in_valid = 1'b1;
        ifc.data     = 32'h0;
        ifc.crc_in   = 16'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid",    32'(ifc.out_valid), 32'd1);
            check("hold_syndrome", 32'(ifc.syndrome),  32'(exp_syn));
            check("hold_crc_ok",   32'(ifc.crc_ok),    32'd0);
            check("hold_in_ready", 32'(ifc.in_ready),  32'd0);
        end
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        check("hold_released", 32'(ifc.in_ready),  32'd1);
        check("hold_no_valid", 32'(ifc.out_valid), 32'd0);
        check("err_three",     32'(ifc.err_count), 32'd3);

        // Reset in the middle of shifting a failing codeword.
        wait_ready();
        ifc.data     = 32'h0000_0001;
        ifc.crc_in   = 16'h1020;
        ifc.in_valid = 1'b1;
        @(negedge clk);
        ifc.in_valid = 1'b0;
        repeat (19) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_in_ready",  32'(ifc.in_ready),  32'd1);
        check("mid_rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("mid_rst_crc_ok",    32'(ifc.crc_ok),    32'd0);
        check("mid_rst_syndrome",  32'(ifc.syndrome),  32'd0);
        check("mid_rst_err_count", 32'(ifc.err_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run(32'h0000_0001, 16'h1021, 16'h0000);
        check("err_after_rst", 32'(ifc.err_count), 32'd0);

        // 300 corrupted codewords back to back with out_ready tied high.
        ifc.out_ready = 1'b1;
        ifc.in_valid  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            wait_ready();
            ifc.data   = 32'(i * 32'h0101_0107 + 7);
            ifc.crc_in = crc_gen(ifc.data) ^ 16'h8000;
            @(negedge clk);
        end
        ifc.in_valid = 1'b0;
        wait_ready();
        check("err_saturated", 32'(ifc.err_count), 32'd255);
        ifc.out_ready = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
